// File: rtl/game_countdown.sv
// Round timer: counts GAME_SECONDS down to 0, one step every CLK_FREQ pclk cycles, with BCD digits for the overlay.
// Latency: outputs registered, one cycle after start/abort; optional pause via `GAME_TIMER_PAUSE_EN.
module game_countdown #(
    parameter int CLK_FREQ     = 40_000_000,
    parameter int GAME_SECONDS = 30,
    parameter int PS_W         = 26
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    output logic [6:0] time_left,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       time_nonzero,
    output logic       expired
);

    localparam logic [6:0]      GS      = 7'(GAME_SECONDS);
    localparam logic [3:0]      GS_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]      GS_ONES = 4'(GAME_SECONDS % 10);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ - 1);

`ifdef GAME_TIMER_PAUSE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic unused_pause;
    assign unused_pause = pause;
`endif

    state_t          state;
    logic [PS_W-1:0] prescaler;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= S_IDLE;
            time_left    <= GS;
            tens         <= GS_TENS;
            ones         <= GS_ONES;
            prescaler    <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            time_nonzero <= 1'b1;
        end else if (abort) begin
            state        <= S_IDLE;
            time_left    <= GS;
            tens         <= GS_TENS;
            ones         <= GS_ONES;
            prescaler    <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            time_nonzero <= 1'b1;
        end else begin
            expired <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_RUN;
                        time_left    <= GS;
                        tens         <= GS_TENS;
                        ones         <= GS_ONES;
                        prescaler    <= '0;
                        running      <= 1'b1;
                        time_nonzero <= 1'b1;
                    end
                end

                S_RUN: begin
`ifdef GAME_TIMER_PAUSE_EN
                    if (pause) begin
                        // prescaler keeps its value so the partial second is not lost
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end else
`endif
                    if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        time_left <= time_left - 7'd1;
                        if (ones == 4'd0) begin
                            ones <= 4'd9;
                            tens <= tens - 4'd1;
                        end else begin
                            ones <= ones - 4'd1;
                        end
                        if (time_left == 7'd1) begin
                            state        <= S_DONE;
                            expired      <= 1'b1;
                            running      <= 1'b0;
                            time_nonzero <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end

`ifdef GAME_TIMER_PAUSE_EN
                S_PAUSE: begin
                    if (!pause) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
`endif

                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
